// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the full-speed USB receive path.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA     = 2'd1,
        EOP_WAIT = 2'd2,
        DROP     = 2'd3
    } rx_ctrl_state_t;

    // Seven zeros followed by a one, shifted in LSB-first.
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    // PID + 1023 payload bytes + CRC16.
    localparam int unsigned FS_MAX_PKT_BYTES = 1026;

endpackage

// File: rtl/usb_rx_byte_assembler.sv
// Collects unstuffed bits LSB-first into bytes and hands them downstream through a
// one-entry holding register with valid/ready. Flags overrun and packet-length overflow.
module usb_rx_byte_assembler
    import usb_rx_pkg::*;
#(
    parameter int unsigned MAX_BYTES = FS_MAX_PKT_BYTES,
    parameter int unsigned BCNT_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              byte_ready,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    output logic [BCNT_W-1:0] byte_cnt,
    output logic [2:0]        bit_cnt,
    output logic              complete,
    output logic              overrun,
    output logic              limit
);

    logic [7:0] shift_q;
    logic [7:0] shift_next;
    logic       load;

    assign shift_next = {bit_in, shift_q[7:1]};
    assign complete   = bit_valid && (bit_cnt == 3'd7);
    // A finished byte with nowhere to go: the held byte must not be overwritten.
    assign overrun    = complete && byte_valid && !byte_ready;
    assign limit      = complete && (byte_cnt == BCNT_W'(MAX_BYTES));
    assign load       = complete && !overrun && !limit;

    // Shift register and bit position within the current byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (clear) begin
            shift_q <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (bit_valid && !overrun && !limit) begin
            shift_q <= shift_next;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Holding register; reload on the same cycle as a transfer keeps it valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
        end else if (load) begin
            byte_data  <= shift_next;
            byte_valid <= 1'b1;
        end else if (byte_valid && byte_ready) begin
            byte_valid <= 1'b0;
        end
    end

    // Bytes assembled in the current packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (load) begin
            byte_cnt <= byte_cnt + BCNT_W'(1);
        end
    end

endmodule

// File: rtl/usb_rx_unstuff_ctrl.sv
// Full-speed USB receive sequencer: hunts SYNC, gates line bits into the external bit
// unstuffer, discards stuffed-bit slots, assembles bytes and frames packets on SE0.
module usb_rx_unstuff_ctrl
    import usb_rx_pkg::*;
#(
    parameter int unsigned MAX_BYTES = FS_MAX_PKT_BYTES,
    parameter int unsigned BCNT_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_bit_valid,
    input  logic              rx_bit,
    input  logic              rx_se0,
    output logic              us_data_valid,
    output logic              us_data_in,
    input  logic              us_data_ready,
    input  logic              us_data_out,
    input  logic              us_stuff_err,
    output logic              rx_active,
    output logic              rx_pkt_start,
    output logic [7:0]        rx_byte,
    output logic              rx_byte_valid,
    input  logic              rx_byte_ready,
    output logic              rx_pkt_end,
    output logic              rx_pkt_err,
    output logic [BCNT_W-1:0] rx_byte_cnt
);

    rx_ctrl_state_t state_q;
    logic [7:0]     sync_sr_q;
    logic [7:0]     sync_next;
    logic [2:0]     ones_cnt_q;
    logic           drop_q;
    logic           drain_q;     // first EOP_WAIT cycle: unstuffer pipe still emptying
    logic           se0_seen_q;  // DROP has observed SE0 and now waits for it to end

    logic           sync_hit;
    logic           in_pkt;
    logic           slot_drop;
    logic           asm_bit_valid;
    logic           asm_complete;
    logic           asm_overrun;
    logic           asm_limit;
    logic           asm_err;
    logic [2:0]     asm_bit_cnt;
    logic [2:0]     bit_cnt_after;
    logic           cnt_zero_after;
    logic           eop_bad;

    assign us_data_valid = rx_bit_valid && (state_q == DATA);
    assign us_data_in    = rx_bit;

    assign sync_next = {rx_bit, sync_sr_q[7:1]};
    assign sync_hit  = (state_q == IDLE) && rx_bit_valid && (sync_next == SYNC_PATTERN);

    // Unstuffer output is consumed in DATA and in the single drain cycle after SE0.
    assign in_pkt        = (state_q == DATA) || ((state_q == EOP_WAIT) && drain_q);
    assign slot_drop     = in_pkt && us_data_ready && drop_q;
    assign asm_bit_valid = in_pkt && us_data_ready && !drop_q && !us_stuff_err;
    assign asm_err       = asm_overrun || asm_limit;

    // Residual state after the drain cycle decides whether the EOP ended cleanly.
    assign bit_cnt_after  = (asm_bit_valid && !asm_err) ? asm_bit_cnt + 3'd1 : asm_bit_cnt;
    assign cnt_zero_after = (rx_byte_cnt == '0) && !(asm_complete && !asm_err);
    assign eop_bad        = us_stuff_err || asm_err || (bit_cnt_after != 3'd0) || cnt_zero_after;

    usb_rx_byte_assembler #(
        .MAX_BYTES (MAX_BYTES),
        .BCNT_W    (BCNT_W)
    ) u_byte_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (sync_hit),
        .bit_valid  (asm_bit_valid),
        .bit_in     (us_data_out),
        .byte_ready (rx_byte_ready),
        .byte_data  (rx_byte),
        .byte_valid (rx_byte_valid),
        .byte_cnt   (rx_byte_cnt),
        .bit_cnt    (asm_bit_cnt),
        .complete   (asm_complete),
        .overrun    (asm_overrun),
        .limit      (asm_limit)
    );

    // Packet sequencer with sync hunt, stuff tracking and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sync_sr_q    <= 8'h00;
            ones_cnt_q   <= 3'd0;
            drop_q       <= 1'b0;
            drain_q      <= 1'b0;
            se0_seen_q   <= 1'b0;
            rx_active    <= 1'b0;
            rx_pkt_start <= 1'b0;
            rx_pkt_end   <= 1'b0;
            rx_pkt_err   <= 1'b0;
        end else begin
            rx_pkt_start <= 1'b0;
            rx_pkt_end   <= 1'b0;
            rx_pkt_err   <= 1'b0;
            if (slot_drop) begin
                drop_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (sync_hit) begin
                        state_q      <= DATA;
                        sync_sr_q    <= 8'h00;
                        rx_pkt_start <= 1'b1;
                        rx_active    <= 1'b1;
                        ones_cnt_q   <= 3'd0;
                        drop_q       <= 1'b0;
                    end else if (rx_bit_valid) begin
                        sync_sr_q <= sync_next;
                    end
                end
                DATA: begin
                    if (us_data_valid) begin
                        if ((ones_cnt_q == 3'd6) && !rx_bit) begin
                            drop_q     <= 1'b1;
                            ones_cnt_q <= 3'd0;
                        end else if (rx_bit) begin
                            ones_cnt_q <= (ones_cnt_q == 3'd7) ? 3'd7 : ones_cnt_q + 3'd1;
                        end else begin
                            ones_cnt_q <= 3'd0;
                        end
                    end
                    // Errors take priority over a coincident SE0.
                    if (us_stuff_err || asm_err) begin
                        state_q    <= DROP;
                        rx_pkt_end <= 1'b1;
                        rx_pkt_err <= 1'b1;
                        se0_seen_q <= rx_se0;
                    end else if (rx_se0) begin
                        state_q <= EOP_WAIT;
                        drain_q <= 1'b1;
                    end
                end
                EOP_WAIT: begin
                    if (drain_q) begin
                        drain_q    <= 1'b0;
                        rx_pkt_end <= 1'b1;
                        rx_pkt_err <= eop_bad;
                    end
                    if (!rx_se0) begin
                        state_q   <= IDLE;
                        rx_active <= 1'b0;
                    end
                end
                DROP: begin
                    if (rx_se0) begin
                        se0_seen_q <= 1'b1;
                    end else if (se0_seen_q) begin
                        se0_seen_q <= 1'b0;
                        state_q    <= IDLE;
                        rx_active  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
